// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the 5-stage RV32I core.
// Produces the per-buffer stall/nop controls, PC hold and PC redirect.
// Inputs are D-/I-memory handshakes, load-use detection and EX-stage branch resolution.
// A redirect that arrives while a fetch is outstanding is parked in tgt_q.
// The fetch address therefore stays stable until the fetch completes.
// Optional feature: define HAZARD_PERF_CNT_EN to build the performance counters.
// When it is undefined, the perf_* ports read 0.
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_resp,
  input  logic        dmem_req,
  input  logic        dmem_resp,
  input  logic        load_ex,
  input  logic [4:0]  rd_ex,
  input  logic [4:0]  rs1_id,
  input  logic [4:0]  rs2_id,
  input  logic        rs1_used_id,
  input  logic        rs2_used_id,
  input  logic        br_taken_ex,
  input  logic [31:0] br_target_ex,
  output logic        imem_read,
  output logic        stall_pc,
  output logic        pc_redirect,
  output logic [31:0] pc_redirect_addr,
  output logic        stall_if_id,
  output logic        nop_if_id,
  output logic        stall_id_ex,
  output logic        nop_id_ex,
  output logic        stall_ex_mem,
  output logic        nop_ex_mem,
  output logic        stall_mem_wb,
  output logic        nop_mem_wb,
  output logic [31:0] perf_stall_cyc,
  output logic [31:0] perf_dstall_cyc,
  output logic [31:0] perf_flush_cnt
);

  typedef enum logic {RUN, REDIR} state_t;

  state_t      state_q, state_d;
  logic [31:0] tgt_q, tgt_d;
  logic        dstall;
  logic        lu;
  logic        flush;

  assign dstall = dmem_req & ~dmem_resp;
  assign lu     = load_ex & (rd_ex != 5'd0) &
                  ((rs1_used_id & (rs1_id == rd_ex)) | (rs2_used_id & (rs2_id == rd_ex)));

  assign imem_read    = ~rst;
  // These two controls are held low until a multi-cycle EX unit exists.
  assign nop_ex_mem   = 1'b0;
  assign stall_mem_wb = 1'b0;

  // Prioritised hazard rules: produce the buffer controls and the next state / pending target.
  always_comb begin
    stall_pc         = 1'b0;
    pc_redirect      = 1'b0;
    pc_redirect_addr = 32'd0;
    stall_if_id      = 1'b0;
    nop_if_id        = 1'b0;
    stall_id_ex      = 1'b0;
    nop_id_ex        = 1'b0;
    stall_ex_mem     = 1'b0;
    nop_mem_wb       = 1'b0;
    flush            = 1'b0;
    state_d          = state_q;
    tgt_d            = tgt_q;
    if (rst) begin
      state_d = RUN;
      tgt_d   = 32'd0;
    end else begin
      pc_redirect_addr = (state_q == REDIR) ? tgt_q : br_target_ex;
      if (dstall) begin
        // Freeze everything up to EX_MEM; a branch in EX reappears after release.
        stall_pc     = 1'b1;
        stall_if_id  = 1'b1;
        stall_id_ex  = 1'b1;
        stall_ex_mem = 1'b1;
        nop_mem_wb   = 1'b1;
      end else if (state_q == REDIR) begin
        // The outstanding fetch belongs to the wrong path: drop it, then redirect.
        nop_if_id = 1'b1;
        if (imem_resp) begin
          pc_redirect = 1'b1;
          state_d     = RUN;
        end else begin
          stall_pc = 1'b1;
        end
      end else if (br_taken_ex) begin
        nop_if_id = 1'b1;
        nop_id_ex = 1'b1;
        flush     = 1'b1;
        if (imem_resp) begin
          pc_redirect = 1'b1;
        end else begin
          // The fetch address must not change mid-fetch, so park the target.
          stall_pc = 1'b1;
          tgt_d    = br_target_ex;
          state_d  = REDIR;
        end
      end else if (lu) begin
        // One bubble suffices; the load result is then forwarded from MEM.
        stall_pc    = 1'b1;
        stall_if_id = 1'b1;
        nop_id_ex   = 1'b1;
      end else if (!imem_resp) begin
        stall_pc  = 1'b1;
        nop_if_id = 1'b1;
      end
    end
  end

  // State and pending-target registers; reset is folded into the _d terms.
  always_ff @(posedge clk) begin
    state_q <= state_d;
    tgt_q   <= tgt_d;
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cyc_q, stall_cyc_d;
  logic [31:0] dstall_cyc_q, dstall_cyc_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Free-running event counters that wrap at 2^32.
  always_comb begin
    stall_cyc_d  = stall_cyc_q + {31'd0, stall_pc};
    dstall_cyc_d = dstall_cyc_q + {31'd0, dstall};
    flush_cnt_d  = flush_cnt_q + {31'd0, flush};
    if (rst) begin
      stall_cyc_d  = 32'd0;
      dstall_cyc_d = 32'd0;
      flush_cnt_d  = 32'd0;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    stall_cyc_q  <= stall_cyc_d;
    dstall_cyc_q <= dstall_cyc_d;
    flush_cnt_q  <= flush_cnt_d;
  end

  assign perf_stall_cyc  = rst ? 32'd0 : stall_cyc_q;
  assign perf_dstall_cyc = rst ? 32'd0 : dstall_cyc_q;
  assign perf_flush_cnt  = rst ? 32'd0 : flush_cnt_q;
`else
  assign perf_stall_cyc  = 32'd0;
  assign perf_dstall_cyc = 32'd0;
  assign perf_flush_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl.
// A table of single-cycle vectors is applied from the RUN state.
// Hand-written sequences then cover the redirect, D-miss and reset corner cases.
// The expected control vector is packed as:
//   {imem_read, stall_pc, pc_redirect, stall_if_id, nop_if_id, stall_id_ex,
//    nop_id_ex, stall_ex_mem, nop_ex_mem, stall_mem_wb, nop_mem_wb}
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_resp, dmem_req, dmem_resp, load_ex;
  logic [4:0]  rd_ex, rs1_id, rs2_id;
  logic        rs1_used_id, rs2_used_id, br_taken_ex;
  logic [31:0] br_target_ex;
  logic        imem_read, stall_pc, pc_redirect;
  logic [31:0] pc_redirect_addr;
  logic        stall_if_id, nop_if_id, stall_id_ex, nop_id_ex;
  logic        stall_ex_mem, nop_ex_mem, stall_mem_wb, nop_mem_wb;
  logic [31:0] perf_stall_cyc, perf_dstall_cyc, perf_flush_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .imem_resp(imem_resp), .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .load_ex(load_ex), .rd_ex(rd_ex), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
    .br_taken_ex(br_taken_ex), .br_target_ex(br_target_ex),
    .imem_read(imem_read), .stall_pc(stall_pc), .pc_redirect(pc_redirect),
    .pc_redirect_addr(pc_redirect_addr),
    .stall_if_id(stall_if_id), .nop_if_id(nop_if_id),
    .stall_id_ex(stall_id_ex), .nop_id_ex(nop_id_ex),
    .stall_ex_mem(stall_ex_mem), .nop_ex_mem(nop_ex_mem),
    .stall_mem_wb(stall_mem_wb), .nop_mem_wb(nop_mem_wb),
    .perf_stall_cyc(perf_stall_cyc), .perf_dstall_cyc(perf_dstall_cyc),
    .perf_flush_cnt(perf_flush_cnt)
  );

  typedef struct {
    string       name;
    logic        imem_resp, dmem_req, dmem_resp, load_ex;
    logic [4:0]  rd_ex, rs1_id, rs2_id;
    logic        rs1_used_id, rs2_used_id, br_taken_ex;
    logic [31:0] br_target_ex;
    logic [10:0] exp_ctrl;
    logic [31:0] exp_addr;
  } vec_t;

  localparam logic [10:0] C_IDLE  = 11'b100_0000_0000;
  localparam logic [10:0] C_IMISS = 11'b110_0100_0000;
  localparam logic [10:0] C_LU    = 11'b110_1001_0000;
  localparam logic [10:0] C_BRHIT = 11'b101_0101_0000;
  localparam logic [10:0] C_BRMIS = 11'b110_0101_0000;
  localparam logic [10:0] C_DST   = 11'b110_1010_1001;
  localparam logic [10:0] C_RDW   = 11'b110_0100_0000;
  localparam logic [10:0] C_RDGO  = 11'b101_0100_0000;

  vec_t vecs[10];

  function automatic logic [10:0] ctrl_now();
    return {imem_read, stall_pc, pc_redirect, stall_if_id, nop_if_id, stall_id_ex,
            nop_id_ex, stall_ex_mem, nop_ex_mem, stall_mem_wb, nop_mem_wb};
  endfunction

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Compare controls and redirect address right now, one line per transaction.
  task automatic sample(input string nm, input logic [10:0] ec, input logic [31:0] ea);
    logic [10:0] c;
    c = ctrl_now();
    checks++;
    if (c !== ec) begin
      errors++;
      $display("FAIL %s ctrl: got %b, expected %b", nm, c, ec);
    end
    chk32({nm, " addr"}, pc_redirect_addr, ea);
    $display("txn %-14s ctrl=%b addr=0x%08h", nm, c, pc_redirect_addr);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string nm, input logic [10:0] ec, input logic [31:0] ea);
    @(negedge clk);
    sample(nm, ec, ea);
    adv();
  endtask

  task automatic idle();
    imem_resp = 1'b1; dmem_req = 1'b0; dmem_resp = 1'b0; load_ex = 1'b0;
    rd_ex = 5'd0; rs1_id = 5'd0; rs2_id = 5'd0;
    rs1_used_id = 1'b0; rs2_used_id = 1'b0;
    br_taken_ex = 1'b0; br_target_ex = 32'd0;
  endtask

  function automatic vec_t mk(input string nm, input logic ir, input logic dq, input logic dr,
                              input logic ld, input logic [4:0] rd, input logic [4:0] r1,
                              input logic [4:0] r2, input logic u1, input logic u2,
                              input logic br, input logic [31:0] tg,
                              input logic [10:0] ec, input logic [31:0] ea);
    vec_t v;
    v.name = nm; v.imem_resp = ir; v.dmem_req = dq; v.dmem_resp = dr; v.load_ex = ld;
    v.rd_ex = rd; v.rs1_id = r1; v.rs2_id = r2; v.rs1_used_id = u1; v.rs2_used_id = u2;
    v.br_taken_ex = br; v.br_target_ex = tg; v.exp_ctrl = ec; v.exp_addr = ea;
    return v;
  endfunction

  initial begin
    //            name          ir dq dr ld rd  r1  r2 u1 u2 br target        ctrl     addr
    vecs[0] = mk("idle",        1, 0, 0, 0, 0,  0,  0, 0, 0, 0, 32'h1234, C_IDLE,  32'h1234);
    vecs[1] = mk("imiss",       0, 0, 0, 0, 0,  0,  0, 0, 0, 0, 32'h0,    C_IMISS, 32'h0);
    vecs[2] = mk("lu_rs1",      1, 0, 0, 1, 3,  3,  0, 1, 0, 0, 32'h0,    C_LU,    32'h0);
    vecs[3] = mk("lu_unused",   1, 0, 0, 1, 3,  3,  3, 0, 0, 0, 32'h0,    C_IDLE,  32'h0);
    vecs[4] = mk("lu_x0",       1, 0, 0, 1, 0,  0,  0, 1, 1, 0, 32'h0,    C_IDLE,  32'h0);
    vecs[5] = mk("no_load",     1, 0, 0, 0, 7,  7,  7, 1, 1, 0, 32'h0,    C_IDLE,  32'h0);
    vecs[6] = mk("br_and_lu",   1, 0, 0, 1, 4,  0,  4, 0, 1, 1, 32'h60,   C_BRHIT, 32'h60);
    vecs[7] = mk("dstall_br",   0, 1, 0, 0, 0,  0,  0, 0, 0, 1, 32'h44,   C_DST,   32'h44);
    vecs[8] = mk("dmem_done",   1, 1, 1, 0, 0,  0,  0, 0, 0, 0, 32'h0,    C_IDLE,  32'h0);
    vecs[9] = mk("lu_imiss",    0, 0, 0, 1, 9,  0,  9, 0, 1, 0, 32'h0,    C_LU,    32'h0);

    idle();
    rst = 1'b1;
    @(negedge clk);
    sample("reset", 11'd0, 32'd0);
    chk32("reset perf_stall", perf_stall_cyc, 32'd0);
    chk32("reset perf_dstall", perf_dstall_cyc, 32'd0);
    chk32("reset perf_flush", perf_flush_cnt, 32'd0);
    adv();
    rst = 1'b0;

    // Table: each vector leaves the controller in RUN.
    for (int i = 0; i < 10; i++) begin
      imem_resp = vecs[i].imem_resp; dmem_req = vecs[i].dmem_req;
      dmem_resp = vecs[i].dmem_resp; load_ex = vecs[i].load_ex;
      rd_ex = vecs[i].rd_ex; rs1_id = vecs[i].rs1_id; rs2_id = vecs[i].rs2_id;
      rs1_used_id = vecs[i].rs1_used_id; rs2_used_id = vecs[i].rs2_used_id;
      br_taken_ex = vecs[i].br_taken_ex; br_target_ex = vecs[i].br_target_ex;
      cyc(vecs[i].name, vecs[i].exp_ctrl, vecs[i].exp_addr);
    end

    // Fresh reset so that the counters cover only the scenarios below.
    idle();
    rst = 1'b1;
    cyc("reset2", 11'd0, 32'd0);
    rst = 1'b0;

    // Load-use: one bubble, then quiet.
    load_ex = 1'b1; rd_ex = 5'd5; rs2_id = 5'd5; rs2_used_id = 1'b1;
    cyc("lu", C_LU, 32'd0);
    load_ex = 1'b0;
    cyc("lu_after", C_IDLE, 32'd0);

    // Branch with the fetch hit: immediate redirect, stays RUN.
    idle(); br_taken_ex = 1'b1; br_target_ex = 32'h60;
    cyc("br_hit", C_BRHIT, 32'h60);
    idle();
    cyc("br_hit_after", C_IDLE, 32'h0);

    // Branch during a fetch miss: 3 held cycles, redirect on cycle 4.
    idle(); br_taken_ex = 1'b1; br_target_ex = 32'h80; imem_resp = 1'b0;
    cyc("brmiss_c1", C_BRMIS, 32'h80);
    br_taken_ex = 1'b0; br_target_ex = 32'hDEAD;
    cyc("brmiss_c2", C_RDW, 32'h80);
    cyc("brmiss_c3", C_RDW, 32'h80);
    imem_resp = 1'b1;
    cyc("brmiss_c4", C_RDGO, 32'h80);
    idle();
    cyc("brmiss_after", C_IDLE, 32'h0);

    // D-miss with a branch in EX: 4 frozen cycles, redirect on release.
    idle(); dmem_req = 1'b1; br_taken_ex = 1'b1; br_target_ex = 32'hA0;
    for (int k = 0; k < 4; k++) cyc($sformatf("dmiss_%0d", k), C_DST, 32'hA0);
    dmem_resp = 1'b1;
    @(negedge clk);
`ifdef HAZARD_PERF_CNT_EN
    chk32("perf_stall", perf_stall_cyc, 32'd8);
    chk32("perf_dstall", perf_dstall_cyc, 32'd4);
    chk32("perf_flush", perf_flush_cnt, 32'd2);
`else
    chk32("perf_stall", perf_stall_cyc, 32'd0);
    chk32("perf_dstall", perf_dstall_cyc, 32'd0);
    chk32("perf_flush", perf_flush_cnt, 32'd0);
`endif
    sample("dmiss_release", C_BRHIT, 32'hA0);
    adv();

    // D-stall while a redirect is pending: REDIR persists and the fetch completes again.
    idle(); br_taken_ex = 1'b1; br_target_ex = 32'hB0; imem_resp = 1'b0;
    cyc("redir_enter", C_BRMIS, 32'hB0);
    br_taken_ex = 1'b0; br_target_ex = 32'h0; imem_resp = 1'b1;
    dmem_req = 1'b1; dmem_resp = 1'b0;
    cyc("redir_dstall", C_DST, 32'hB0);
    dmem_req = 1'b0;
    cyc("redir_release", C_RDGO, 32'hB0);

    // Reset while REDIR is pending discards the redirect.
    idle(); br_taken_ex = 1'b1; br_target_ex = 32'hC0; imem_resp = 1'b0;
    cyc("rst_redir_in", C_BRMIS, 32'hC0);
    rst = 1'b1; br_taken_ex = 1'b0;
    cyc("rst_redir_rst", 11'd0, 32'd0);
    rst = 1'b0; imem_resp = 1'b1; br_target_ex = 32'h0;
    cyc("rst_redir_out", C_IDLE, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
